// File: rtl/light_pkg.sv
// Shared definitions for the traffic-light timer and its controller:
// selector ids, parameter-select codes, default durations and widths.
package light_pkg;

    localparam int DUR_W   = 5;  // decoded duration / seconds_left width
    localparam int PARAM_W = 4;  // programmable parameter width

    localparam int DEF_BASE_SEC = 6;
    localparam int DEF_EXT_SEC  = 3;
    localparam int DEF_YEL_SEC  = 2;

    typedef enum logic [1:0] {
        tBASE_id   = 2'b00,
        tEXT_id    = 2'b01,
        tYEL_id    = 2'b10,
        tBASEx2_id = 2'b11
    } time_sel_e;

    typedef enum logic [1:0] {
        PSEL_BASE = 2'b00,
        PSEL_EXT  = 2'b01,
        PSEL_YEL  = 2'b10,
        PSEL_NONE = 2'b11
    } param_sel_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } timer_state_e;

    // Parameters are never 0, so neither is any decoded duration.
    function automatic logic [DUR_W-1:0] decode_duration(
        input logic [1:0]         sel,
        input logic [PARAM_W-1:0] base,
        input logic [PARAM_W-1:0] ext,
        input logic [PARAM_W-1:0] yel
    );
        logic [DUR_W-1:0] dur;
        case (time_sel_e'(sel))
            tBASE_id:   dur = {1'b0, base};
            tEXT_id:    dur = {1'b0, ext};
            tYEL_id:    dur = {1'b0, yel};
            tBASEx2_id: dur = {base, 1'b0};
            default:    dur = {1'b0, base};
        endcase
        return dur;
    endfunction

endpackage

// File: rtl/light_timer_if.sv
// Controller <-> timer bus: programming strobe, start handshake and status.
interface light_timer_if;
    logic       Prog_Sync;
    logic [1:0] time_param_sel;
    logic [3:0] time_value;
    logic       start_timer;
    logic [1:0] time_selector;
    logic       expired;
    logic       busy;
    logic [4:0] seconds_left;

    modport master (
        output Prog_Sync, time_param_sel, time_value, start_timer, time_selector,
        input  expired, busy, seconds_left
    );

    modport slave (
        input  Prog_Sync, time_param_sel, time_value, start_timer, time_selector,
        output expired, busy, seconds_left
    );
endinterface

// File: rtl/light_timer_tick_prescaler.sv
// Free-running divider producing a one-cycle tick every DIV enabled cycles;
// held at zero while disabled and restarted by clear.
module tick_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt_q, cnt_d;
    logic         wrap;

    assign wrap = (cnt_q == W'(DIV - 1));
    assign tick = enable && wrap;

    // NOTE: every comb-assigned signal gets a default first so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clear || !enable) begin
            cnt_d = '0;
        end else if (wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/light_timer.sv
// Interval timer for the traffic-light controller: programmable durations,
// 1 Hz timebase, one-cycle expired pulse. LIGHT_TIMER_FAST_SIM_EN divides by 4.
module light_timer
    import light_pkg::*;
#(
    parameter int CLK_DIV  = 100_000_000,
    parameter int DEF_BASE = DEF_BASE_SEC,
    parameter int DEF_EXT  = DEF_EXT_SEC,
    parameter int DEF_YEL  = DEF_YEL_SEC
) (
    input  logic            clk,
    input  logic            Reset,
    light_timer_if.slave    bus
);
`ifdef LIGHT_TIMER_FAST_SIM_EN
    localparam int PRESC_DIV = 4;
`else
    localparam int PRESC_DIV = CLK_DIV;
`endif

    localparam logic [PARAM_W-1:0] BASE_RST = PARAM_W'(DEF_BASE);
    localparam logic [PARAM_W-1:0] EXT_RST  = PARAM_W'(DEF_EXT);
    localparam logic [PARAM_W-1:0] YEL_RST  = PARAM_W'(DEF_YEL);

    logic [PARAM_W-1:0] base_q, base_d;
    logic [PARAM_W-1:0] ext_q, ext_d;
    logic [PARAM_W-1:0] yel_q, yel_d;

    timer_state_e       state_q, state_d;
    logic [DUR_W-1:0]   counter_q, counter_d;
    logic               expired_q, expired_d;
    logic               tick;
    logic               running;

    assign running = (state_q == ST_RUN);

    // Programming: a zero value restores that register's default.
    always_comb begin
        base_d = base_q;
        ext_d  = ext_q;
        yel_d  = yel_q;
        if (bus.Prog_Sync) begin
            case (param_sel_e'(bus.time_param_sel))
                PSEL_BASE: base_d = (bus.time_value == '0) ? BASE_RST : bus.time_value;
                PSEL_EXT:  ext_d  = (bus.time_value == '0) ? EXT_RST  : bus.time_value;
                PSEL_YEL:  yel_d  = (bus.time_value == '0) ? YEL_RST  : bus.time_value;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            base_q <= BASE_RST;
            ext_q  <= EXT_RST;
            yel_q  <= YEL_RST;
        end else begin
            base_q <= base_d;
            ext_q  <= ext_d;
            yel_q  <= yel_d;
        end
    end

    tick_prescaler #(
        .DIV (PRESC_DIV)
    ) u_prescaler (
        .clk    (clk),
        .Reset  (Reset),
        .clear  (bus.start_timer),
        .enable (running),
        .tick   (tick)
    );

    // State register
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            counter_q <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            expired_q <= expired_d;
        end
    end

    // Next state: a start always wins over a coincident final tick, and the
    // decode sees the pre-programming register values.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        expired_d = 1'b0;
        if (bus.start_timer) begin
            state_d   = ST_RUN;
            counter_d = decode_duration(bus.time_selector, base_q, ext_q, yel_q);
        end else if (running && tick) begin
            counter_d = counter_q - 1'b1;
            if (counter_q == DUR_W'(1)) begin
                state_d   = ST_IDLE;
                expired_d = 1'b1;
            end
        end
    end

    // Outputs
    always_comb begin
        bus.busy         = running;
        bus.expired      = expired_q;
        bus.seconds_left = counter_q;
    end
endmodule

// File: tb/tb_light_timer.sv
// Directed bench for light_timer with CLK_DIV=10 and default durations.
module tb_light_timer;
    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    light_timer_if bus ();

    light_timer #(
        .CLK_DIV (10)
    ) dut (
        .clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic program_param(input logic [1:0] psel, input logic [3:0] val);
        @(negedge clk);
        bus.Prog_Sync      = 1'b1;
        bus.time_param_sel = psel;
        bus.time_value     = val;
        @(posedge clk);
        #1;
        bus.Prog_Sync      = 1'b0;
    endtask

    // Returns one time unit after the start edge (cycle 0 of the interval).
    task automatic start_interval(input logic [1:0] sel);
        @(negedge clk);
        bus.start_timer   = 1'b1;
        bus.time_selector = sel;
        @(posedge clk);
        #1;
        bus.start_timer   = 1'b0;
    endtask

    // Cycles from the start edge until expired is seen; -1 if the budget runs out.
    task automatic wait_expired(input int budget, output int k);
        k = 0;
        while (k < budget) begin
            step();
            k++;
            if (bus.expired === 1'b1) return;
        end
        k = -1;
    endtask

    int k;
    int hits;

    initial begin
        rst                = 1'b1;
        bus.Prog_Sync      = 1'b0;
        bus.time_param_sel = 2'b11;
        bus.time_value     = 4'd0;
        bus.start_timer    = 1'b0;
        bus.time_selector  = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_expired", int'(bus.expired), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_secs", int'(bus.seconds_left), 0);
        @(negedge clk);
        rst = 1'b0;

        // Base interval, cycle-exact countdown
        start_interval(2'b00);
        for (int s = 6; s >= 1; s--) begin
            check("base_secs", int'(bus.seconds_left), s);
            check("base_busy", int'(bus.busy), 1);
            if (s > 1) repeat (10) step();
        end
        repeat (9) step();
        check("base_exp_c59", int'(bus.expired), 0);
        step();
        check("base_exp_c60", int'(bus.expired), 1);
        check("base_busy_c60", int'(bus.busy), 0);
        check("base_secs_c60", int'(bus.seconds_left), 0);
        step();
        check("base_exp_c61", int'(bus.expired), 0);

        // Programmed yellow, then default restored by value 0
        program_param(2'b10, 4'd5);
        start_interval(2'b10);
        wait_expired(200, k);
        check("yel5_cycles", k, 50);
        program_param(2'b10, 4'd0);
        start_interval(2'b10);
        wait_expired(200, k);
        check("yel_def_cycles", k, 20);

        // Double base with base=15; sel=11 on programming is ignored
        program_param(2'b00, 4'd15);
        program_param(2'b11, 4'd9);
        start_interval(2'b11);
        check("x2_secs", int'(bus.seconds_left), 30);
        wait_expired(400, k);
        check("x2_cycles", k, 300);
        program_param(2'b00, 4'd0);

        // Restart at cycle 35 with ext: expiry 30 cycles after restart
        start_interval(2'b00);
        hits = 0;
        repeat (34) begin
            step();
            if (bus.expired === 1'b1) hits++;
        end
        start_interval(2'b01);
        check("restart_secs", int'(bus.seconds_left), 3);
        wait_expired(200, k);
        check("restart_cycles", k, 30);
        check("restart_early_exp", hits, 0);

        // Start in the same cycle as the final tick (yel=2: final edge is 20)
        start_interval(2'b10);
        repeat (19) step();
        start_interval(2'b01);
        check("coinc_expired", int'(bus.expired), 0);
        check("coinc_busy", int'(bus.busy), 1);
        check("coinc_secs", int'(bus.seconds_left), 3);
        wait_expired(200, k);
        check("coinc_cycles", k, 30);

        // Programming together with start: decode uses the old value
        @(negedge clk);
        bus.Prog_Sync      = 1'b1;
        bus.time_param_sel = 2'b10;
        bus.time_value     = 4'd7;
        bus.start_timer    = 1'b1;
        bus.time_selector  = 2'b10;
        @(posedge clk);
        #1;
        bus.Prog_Sync   = 1'b0;
        bus.start_timer = 1'b0;
        check("prog_start_secs", int'(bus.seconds_left), 2);
        wait_expired(200, k);
        check("prog_start_cycles", k, 20);
        start_interval(2'b10);
        wait_expired(200, k);
        check("prog_new_cycles", k, 70);

        // Asynchronous reset mid-interval restores defaults
        program_param(2'b00, 4'd9);
        program_param(2'b01, 4'd7);
        program_param(2'b10, 4'd4);
        start_interval(2'b00);
        repeat (25) step();
        #2 rst = 1'b1;
        #1;
        check("arst_busy", int'(bus.busy), 0);
        check("arst_secs", int'(bus.seconds_left), 0);
        check("arst_expired", int'(bus.expired), 0);
        @(negedge clk);
        rst = 1'b0;
        hits = 0;
        repeat (100) begin
            step();
            if (bus.expired === 1'b1) hits++;
        end
        check("arst_no_exp", hits, 0);
        start_interval(2'b00);
        wait_expired(200, k);
        check("arst_base", k, 60);
        start_interval(2'b01);
        wait_expired(200, k);
        check("arst_ext", k, 30);
        start_interval(2'b10);
        wait_expired(200, k);
        check("arst_yel", k, 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
